// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: forward-select encodings,
// the in-flight scoreboard entry, and the source/entry match helper.
package hazard_pkg;

  localparam int SB_REGW = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_ME   = 2'b10;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic [SB_REGW-1:0] dst;
  } sb_entry_t;

  // A source depends on an entry only if it is really read, is not r0,
  // and the entry is a live register-writing instruction targeting it.
  function automatic logic sb_match(input sb_entry_t e,
                                    input logic [SB_REGW-1:0] src,
                                    input logic uses);
    return e.valid & e.regwrite & (e.dst == src) & (src != '0) & uses;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment until all-ones, then hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    count <= '0;
    else if (inc && (count != '1)) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock / forwarding controller for the four-stage core.
// Tracks the destinations of the instructions in EX and ME, and from them
// derives load-use stalls, EX/ME forwarding selects and the branch flush.
// Optional: define HAZARD_PERF_EN to add saturating stall/flush counters
// (StallCnt, FlushCnt); without it those ports and counters do not exist.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid_ID,
  input  logic [REGW-1:0] Rs_ID,
  input  logic [REGW-1:0] Rt_ID,
  input  logic            UsesRs_ID,
  input  logic            UsesRt_ID,
  input  logic            RegWrite_ID,
  input  logic            MemToReg_ID,
  input  logic [REGW-1:0] WriteReg_ID,
  input  logic            Stall_EX,
  input  logic            BranchTaken_EX,
  output logic            AnyStall,
  output logic            Bubble_EX,
  output logic            Flush_ID,
  output logic [1:0]      FwdA_ID,
  output logic [1:0]      FwdB_ID
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
`endif
);

  // The entry struct carries a fixed-width destination field.
  if (REGW != SB_REGW) begin : g_regw_chk
    $error("hazard_scoreboard: REGW must equal hazard_pkg::SB_REGW");
  end
  if (CNTW < 1) begin : g_cntw_chk
    $error("hazard_scoreboard: CNTW must be at least 1");
  end

  sb_entry_t ex_q, me_q;
  sb_entry_t id_ent;

  logic a_ex, b_ex, a_me, b_me;
  logic load_use, flush, bubble, stall;
  logic [1:0] fwd_a, fwd_b;

  // Decode-stage instruction as it would enter EX.
  always_comb begin
    id_ent          = '0;
    id_ent.valid    = Valid_ID;
    id_ent.regwrite = RegWrite_ID;
    id_ent.memtoreg = MemToReg_ID;
    id_ent.dst      = WriteReg_ID;
  end

  assign a_ex = sb_match(ex_q, Rs_ID, UsesRs_ID);
  assign b_ex = sb_match(ex_q, Rt_ID, UsesRt_ID);
  assign a_me = sb_match(me_q, Rs_ID, UsesRs_ID);
  assign b_me = sb_match(me_q, Rt_ID, UsesRt_ID);

  // A load in EX cannot forward yet: the consumer must wait one cycle.
  assign load_use = (a_ex | b_ex) & ex_q.memtoreg;
  // A taken branch overrides load-use: the consumer is discarded anyway.
  assign flush    = BranchTaken_EX & ~Stall_EX;
  assign stall    = Stall_EX | (load_use & ~flush);
  assign bubble   = load_use & ~Stall_EX & ~BranchTaken_EX;

  // Forward select: non-load EX result first, then whatever ME holds.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (a_ex && !ex_q.memtoreg) fwd_a = FWD_EX;
    else if (a_me)              fwd_a = FWD_ME;
    if (b_ex && !ex_q.memtoreg) fwd_b = FWD_EX;
    else if (b_me)              fwd_b = FWD_ME;
  end

  // Outputs are forced quiet while reset is held, even with inputs active.
  assign AnyStall  = reset & stall;
  assign Bubble_EX = reset & bubble;
  assign Flush_ID  = reset & flush;
  assign FwdA_ID   = reset ? fwd_a : FWD_NONE;
  assign FwdB_ID   = reset ? fwd_b : FWD_NONE;

  // Scoreboard shift on advance; a bubbled or flushed slot enters EX empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
      me_q <= '0;
    end else if (!Stall_EX) begin
      me_q <= ex_q;
      ex_q <= (Valid_ID && !bubble && !flush) ? id_ent : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (AnyStall),
    .count (StallCnt)
  );

  sat_counter #(.WIDTH(CNTW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Flush_ID),
    .count (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle decode
// inputs with hand-derived expected outputs, plus stall/branch/reset
// sequences. Expectations are queued at drive time and checked mid-cycle.
module tb_hazard_scoreboard;

  localparam int REGW = 5;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            Valid_ID, UsesRs_ID, UsesRt_ID, RegWrite_ID, MemToReg_ID;
  logic [REGW-1:0] Rs_ID, Rt_ID, WriteReg_ID;
  logic            Stall_EX, BranchTaken_EX;
  logic            AnyStall, Bubble_EX, Flush_ID;
  logic [1:0]      FwdA_ID, FwdB_ID;
`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] StallCnt, FlushCnt;
`endif

  hazard_scoreboard #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .reset          (reset),
    .Valid_ID       (Valid_ID),
    .Rs_ID          (Rs_ID),
    .Rt_ID          (Rt_ID),
    .UsesRs_ID      (UsesRs_ID),
    .UsesRt_ID      (UsesRt_ID),
    .RegWrite_ID    (RegWrite_ID),
    .MemToReg_ID    (MemToReg_ID),
    .WriteReg_ID    (WriteReg_ID),
    .Stall_EX       (Stall_EX),
    .BranchTaken_EX (BranchTaken_EX),
    .AnyStall       (AnyStall),
    .Bubble_EX      (Bubble_EX),
    .Flush_ID       (Flush_ID),
    .FwdA_ID        (FwdA_ID),
    .FwdB_ID        (FwdB_ID)
`ifdef HAZARD_PERF_EN
    ,
    .StallCnt       (StallCnt),
    .FlushCnt       (FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    int         rs, rt;
    logic       urs, urt, rw, m2r;
    int         wr;
    logic       stall, br;
    logic       any, bub, fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mdl_stall = 0;
  int   mdl_flush = 0;

  function automatic vec_t mk(logic valid, int rs, int rt, logic urs, logic urt,
                              logic rw, logic m2r, int wr, logic stall, logic br,
                              logic any, logic bub, logic fl,
                              logic [1:0] fa, logic [1:0] fb);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.rw = rw; v.m2r = m2r; v.wr = wr; v.stall = stall; v.br = br;
    v.any = any; v.bub = bub; v.fl = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    Valid_ID       = v.valid;
    Rs_ID          = REGW'(v.rs);
    Rt_ID          = REGW'(v.rt);
    UsesRs_ID      = v.urs;
    UsesRt_ID      = v.urt;
    RegWrite_ID    = v.rw;
    MemToReg_ID    = v.m2r;
    WriteReg_ID    = REGW'(v.wr);
    Stall_EX       = v.stall;
    BranchTaken_EX = v.br;
  endtask

  // Drive one cycle just after the edge, check its outputs mid-cycle.
  task automatic cyc(input string tag, input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp({tag, ".AnyStall"},  int'(AnyStall),  int'(e.any));
    cmp({tag, ".Bubble_EX"}, int'(Bubble_EX), int'(e.bub));
    cmp({tag, ".Flush_ID"},  int'(Flush_ID),  int'(e.fl));
    cmp({tag, ".FwdA_ID"},   int'(FwdA_ID),   int'(e.fa));
    cmp({tag, ".FwdB_ID"},   int'(FwdB_ID),   int'(e.fb));
    if (reset) begin
      mdl_stall += int'(e.any);
      mdl_flush += int'(e.fl);
    end
  endtask

  task automatic chk_quiet(input string tag);
    cmp({tag, ".AnyStall"},  int'(AnyStall),  0);
    cmp({tag, ".Bubble_EX"}, int'(Bubble_EX), 0);
    cmp({tag, ".Flush_ID"},  int'(Flush_ID),  0);
    cmp({tag, ".FwdA_ID"},   int'(FwdA_ID),   0);
    cmp({tag, ".FwdB_ID"},   int'(FwdB_ID),   0);
`ifdef HAZARD_PERF_EN
    cmp({tag, ".StallCnt"},  int'(StallCnt),  0);
    cmp({tag, ".FlushCnt"},  int'(FlushCnt),  0);
`endif
  endtask

  initial begin
    //           vld rs  rt  urs urt rw m2r wr stl br  any bub fl fa     fb
    tbl[0]  = mk(1,  1,  0,  1,  0,  1, 1,  2, 0,  0,  0,  0,  0, 2'b00, 2'b00); // lw $2
    tbl[1]  = mk(1,  2,  4,  1,  1,  1, 0,  3, 0,  0,  1,  1,  0, 2'b00, 2'b00); // add $3,$2,$4 load-use
    tbl[2]  = mk(1,  2,  4,  1,  1,  1, 0,  3, 0,  0,  0,  0,  0, 2'b10, 2'b00); // replay: load now in ME
    tbl[3]  = mk(1,  1,  1,  1,  1,  1, 0,  2, 0,  0,  0,  0,  0, 2'b00, 2'b00); // add $2,$1,$1
    tbl[4]  = mk(1,  2,  2,  1,  1,  1, 0,  5, 0,  0,  0,  0,  0, 2'b01, 2'b01); // sub $5,$2,$2
    tbl[5]  = mk(1,  7,  7,  1,  1,  1, 0,  2, 0,  0,  0,  0,  0, 2'b00, 2'b00); // add $2,$7,$7
    tbl[6]  = mk(0,  0,  0,  0,  0,  0, 0,  0, 0,  0,  0,  0,  0, 2'b00, 2'b00); // nop
    tbl[7]  = mk(1,  2,  0,  1,  1,  1, 0,  6, 0,  0,  0,  0,  0, 2'b10, 2'b00); // or $6,$2,$0
    tbl[8]  = mk(1,  1,  1,  1,  1,  1, 0,  6, 0,  0,  0,  0,  0, 2'b00, 2'b00); // add $6,$1,$1
    tbl[9]  = mk(1,  6,  6,  1,  1,  1, 0,  8, 0,  0,  0,  0,  0, 2'b01, 2'b01); // $6 in EX and ME: EX wins
    tbl[10] = mk(1,  1,  0,  1,  0,  1, 1,  9, 0,  0,  0,  0,  0, 2'b00, 2'b00); // lw $9
    tbl[11] = mk(1,  9,  0,  1,  1,  1, 0, 10, 0,  1,  0,  0,  1, 2'b00, 2'b00); // branch + load-use: flush
    tbl[12] = mk(1,  9,  9,  1,  1,  1, 0, 11, 0,  0,  0,  0,  0, 2'b10, 2'b10); // EX empty, load in ME
    tbl[13] = mk(1,  0,  0,  1,  1,  1, 1, 12, 0,  0,  0,  0,  0, 2'b00, 2'b00); // lw $12
    tbl[14] = mk(1,  1, 12,  1,  1,  0, 0,  0, 0,  0,  1,  1,  0, 2'b00, 2'b00); // sw via Rt: load-use
    tbl[15] = mk(1,  1, 12,  1,  1,  0, 0,  0, 0,  0,  0,  0,  0, 2'b00, 2'b10); // replay: Rt from ME

    // Reset state with hazard-provoking inputs held active.
    apply(mk(1, 2, 2, 1, 1, 1, 1, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00));
    #12;
    chk_quiet("reset");
    @(posedge clk);
    #1;
    chk_quiet("reset_edge");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    reset = 1'b1;

    for (int i = 0; i < 16; i++) cyc($sformatf("tbl%0d", i), tbl[i]);

    // Stall_EX for 3 cycles with a load-use pair waiting: scoreboard frozen.
    cyc("lw13", mk(1, 0, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("stall%0d", i), mk(1, 13, 13, 1, 1, 1, 0, 14, 1, 0, 1, 0, 0, 2'b00, 2'b00));
    cyc("after_stall", mk(1, 13, 13, 1, 1, 1, 0, 14, 0, 0, 1, 1, 0, 2'b00, 2'b00));
    cyc("ld_fwd_me",   mk(1, 13, 13, 1, 1, 1, 0, 14, 0, 0, 0, 0, 0, 2'b10, 2'b10));

    // Taken branch under Stall_EX is deferred until the pipe advances.
    cyc("br_stalled", mk(1, 14, 0, 1, 0, 1, 0, 15, 1, 1, 1, 0, 0, 2'b01, 2'b00));
    cyc("br_taken",   mk(1, 14, 0, 1, 0, 1, 0, 15, 0, 1, 0, 0, 1, 2'b01, 2'b00));

    // Reset pulsed during a stall with a live EX forward.
    cyc("add2",    mk(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    cyc("pre_rst", mk(1, 2, 2, 1, 1, 1, 0, 5, 1, 0, 1, 0, 0, 2'b01, 2'b01));
`ifdef HAZARD_PERF_EN
    @(posedge clk);
    #1;
    cmp("StallCnt", int'(StallCnt), mdl_stall);
    cmp("FlushCnt", int'(FlushCnt), mdl_flush);
    @(negedge clk);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("mid_rst");
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    reset = 1'b1;
    mdl_stall = 0;
    mdl_flush = 0;
    cyc("post_rst", mk(1, 2, 2, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    cyc("post_rst_ld", mk(1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    cyc("post_rst_lu", mk(1, 3, 0, 1, 0, 1, 0, 4, 0, 1, 0, 0, 1, 2'b00, 2'b00));

`ifdef HAZARD_PERF_EN
    @(posedge clk);
    #1;
    cmp("StallCnt_end", int'(StallCnt), mdl_stall);
    cmp("FlushCnt_end", int'(FlushCnt), mdl_flush);
`endif

    cmp("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
